opl2_reg_writer: RTL
====================

Name: opl2_reg_writer

Overview:
Bus initiator that drives the OPL2 interface's CPU-side port (addr/din/we) from a stream of register-write commands. Each command is {register, data, delay} in IMF-style playback form. For each command the block issues an index write, then a data write, with OPL2-legal gaps, then waits a programmable number of playback ticks. It sits between a music/sequence source (ROM reader, FIFO, or CPU mailbox) and the OPL2 interface, so the sound core can be driven without a CPU.

Parameters:
WE_CYCLES, 2, clk cycles `we` is held high per bus write; minimum 1.
ADDR_WAIT, 231, clk cycles `we` is held low after an index write (3.3 us at 70 MHz).
DATA_WAIT, 1610, clk cycles `we` is held low after a data write (23 us at 70 MHz).
TICK_CYCLES, 125000, clk cycles per delay tick (560 Hz at 70 MHz).

Ports:
clk  in  1  system clock (same clock as the OPL2 interface's `clk`)
rst  in  1  synchronous reset, active-high
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
cmd_reg  in  8  OPL2 register index
cmd_data  in  8  register value
cmd_delay  in  16  ticks to wait after the data write; 0 = none
abort  in  1  synchronous abort of the current command
pause  in  1  freezes the tick countdown in DELAY only
addr  out  1  to OPL2 interface addr: 0 = index port, 1 = data port
dout  out  8  to OPL2 interface din
we  out  1  to OPL2 interface we; the interface detects its rising edge
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (rst high at a clk edge):
  - state=IDLE; addr=0, dout=0, we=0, busy=0.
  - cmd_ready=0 while rst is high; cmd_ready=1 from the first cycle after rst drops.
  - All counters are cleared.
- All outputs are registered, except cmd_ready = (state==IDLE) & ~rst.
- States: IDLE, ADDR_WR, ADDR_GAP, DATA_WR, DATA_GAP, DELAY.
- IDLE:
  - On handshake, latch reg/data/delay and go to ADDR_WR.
  - No-handshake cycles leave all outputs unchanged.
- ADDR_WR: addr=0, dout=reg, we=1 for exactly WE_CYCLES cycles, then ADDR_GAP.
- ADDR_GAP: we=0 (addr/dout hold) for ADDR_WAIT cycles, then DATA_WR.
- DATA_WR: addr=1, dout=data, we=1 for WE_CYCLES cycles, then DATA_GAP.
- DATA_GAP: we=0 for DATA_WAIT cycles; then DELAY if delay!=0, else IDLE.
- DELAY:
  - Tick prescaler restarts on entry.
  - Stays exactly delay*TICK_CYCLES non-paused cycles, then IDLE.
  - pause high stalls both the prescaler and the tick counter; resume continues where it left off.
- Timing from the accept edge T:
  - First we=1 cycle is T+1.
  - cmd_ready returns at T + 1 + 2*WE_CYCLES + ADDR_WAIT + DATA_WAIT + delay*TICK_CYCLES (no pause).
- Consecutive writes: we is always low for at least min(ADDR_WAIT, DATA_WAIT) ≥ 1 cycle between high phases, so every write produces a distinct rising edge.
- abort:
  - Any state goes to IDLE at the next edge; we=0 at that edge; addr and dout hold.
  - A partially issued index write is left latched in the OPL2 interface. This is harmless and the next command rewrites it.
  - abort in IDLE has no effect.
  - abort and cmd_valid together in IDLE: abort wins and no handshake occurs (cmd_ready forced 0 while abort is high).
- Width rules:
  - Gap counters are sized $clog2(max(ADDR_WAIT, DATA_WAIT)+1).
  - Prescaler is sized $clog2(TICK_CYCLES).
  - Tick counter is 16 bits.
  - cmd_delay=16'hFFFF must not wrap.
- Parameters of 0 for ADDR_WAIT or DATA_WAIT are illegal; assert at elaboration.

Decomposition:
- Package opl2_pkg:
  - State enum opl2_wr_state_t.
  - Port selector constants OPL2_PORT_INDEX=0 and OPL2_PORT_DATA=1.
  - Register address constants: timer1=8'h02, timer2=8'h03, timer ctrl=8'h04.
- Sub-module opl2_tick_gen: prescaler with restart and enable inputs and a one-cycle tick output; instantiated once.

Test Plan:
Use bench parameters WE_CYCLES=2, ADDR_WAIT=4, DATA_WAIT=8, TICK_CYCLES=10.
1. Single write: reg=8'h20, data=8'h01, delay=0, accepted at T -> we=1 at T+1..T+2 with addr=0, dout=8'h20; we=0 at T+3..T+6; we=1 at T+7..T+8 with addr=1, dout=8'h01; we=0 at T+9..T+16; cmd_ready=1 at T+17.
2. Delay: same command with delay=3 -> cmd_ready at T+47; busy high T+1..T+46.
3. Back-to-back: cmd_valid held with 3 commands -> exactly 6 we rising edges. A connected OPL2 interface model sees index then data for each, in order.
4. Pause: delay=2, pause high for 7 cycles mid-DELAY -> cmd_ready at T+44.
5. Abort: abort during DATA_WR at T+7 -> we=0 and state IDLE at T+8, cmd_ready=1 at T+8. Also abort during DELAY -> same one-cycle return to IDLE.
6. Reset: rst asserted during ADDR_GAP -> next cycle addr=0, dout=0, we=0, busy=0, cmd_ready=0; cmd_ready=1 the cycle after rst drops. Also delay=16'hFFFF with TICK_CYCLES=1 runs 65535 DELAY cycles with no wrap.

Source files
------------

// File: rtl/opl2_pkg.sv
`default_nettype none
// ============================================================================
// Module   : opl2_pkg
// Brief    : Shared types and constants for the OPL2 register-write initiator.
// Revision : 1.0 - initial release
// ============================================================================
package opl2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ADDR_WR  = 3'd1,
        ST_ADDR_GAP = 3'd2,
        ST_DATA_WR  = 3'd3,
        ST_DATA_GAP = 3'd4,
        ST_DELAY    = 3'd5
    } opl2_wr_state_t;

    localparam logic OPL2_PORT_INDEX = 1'b0;
    localparam logic OPL2_PORT_DATA  = 1'b1;

    localparam logic [7:0] OPL2_REG_TIMER1    = 8'h02;
    localparam logic [7:0] OPL2_REG_TIMER2    = 8'h03;
    localparam logic [7:0] OPL2_REG_TIMER_CTL = 8'h04;

    function automatic int opl2_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/opl2_tick_gen.sv
`default_nettype none
// ============================================================================
// Module   : opl2_tick_gen
// Brief    : Playback-tick prescaler with restart and enable; one-cycle tick.
// Revision : 1.0 - initial release
// ============================================================================
module opl2_tick_gen #(
    parameter int TICK_CYCLES = 125000
) (
    input  logic clk,
    input  logic rst,
    input  logic restart_i,
    input  logic en_i,
    output logic tick_o
);

    localparam int            PW   = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [PW-1:0] LAST = PW'(TICK_CYCLES - 1);

    logic [PW-1:0] cnt_q;
    logic [PW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (restart_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Tick fires on the last enabled count so a stalled prescaler never ticks.
    assign tick_o = en_i & ~restart_i & (cnt_q == LAST);

endmodule
`default_nettype wire

// File: rtl/opl2_reg_writer.sv
`default_nettype none
// ============================================================================
// Module   : opl2_reg_writer
// Brief    : Drives OPL2 index/data writes from {reg,data,delay} commands.
// Revision : 1.0 - initial release
// ============================================================================
module opl2_reg_writer
    import opl2_pkg::*;
#(
    parameter int WE_CYCLES   = 2,
    parameter int ADDR_WAIT   = 231,
    parameter int DATA_WAIT   = 1610,
    parameter int TICK_CYCLES = 125000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_reg,
    input  logic [7:0]  cmd_data,
    input  logic [15:0] cmd_delay,
    input  logic        abort,
    input  logic        pause,
    output logic        addr,
    output logic [7:0]  dout,
    output logic        we,
    output logic        busy
);

    localparam int GW = $clog2(opl2_max(ADDR_WAIT, DATA_WAIT) + 1);
    localparam int WW = (WE_CYCLES > 1) ? $clog2(WE_CYCLES) : 1;

    localparam logic [WW-1:0] WE_LOAD   = WW'(WE_CYCLES - 1);
    localparam logic [GW-1:0] AGAP_LOAD = GW'(ADDR_WAIT - 1);
    localparam logic [GW-1:0] DGAP_LOAD = GW'(DATA_WAIT - 1);

    if (ADDR_WAIT < 1 || DATA_WAIT < 1) begin : g_bad_wait
        $error("opl2_reg_writer: ADDR_WAIT and DATA_WAIT must be at least 1");
    end
    if (WE_CYCLES < 1 || TICK_CYCLES < 1) begin : g_bad_cycles
        $error("opl2_reg_writer: WE_CYCLES and TICK_CYCLES must be at least 1");
    end

    opl2_wr_state_t state_q, state_d;
    logic           addr_q, addr_d;
    logic [7:0]     dout_q, dout_d;
    logic           we_q, we_d;
    logic           busy_q, busy_d;
    logic [7:0]     data_q, data_d;
    logic [15:0]    ticks_q, ticks_d;
    logic [WW-1:0]  we_cnt_q, we_cnt_d;
    logic [GW-1:0]  gap_cnt_q, gap_cnt_d;
    logic           tick_w;

    opl2_tick_gen #(
        .TICK_CYCLES (TICK_CYCLES)
    ) u_tick_gen (
        .clk       (clk),
        .rst       (rst),
        .restart_i (state_q != ST_DELAY),
        .en_i      (~pause),
        .tick_o    (tick_w)
    );

    assign cmd_ready = (state_q == ST_IDLE) & ~rst & ~abort;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        dout_d    = dout_q;
        we_d      = we_q;
        data_d    = data_q;
        ticks_d   = ticks_q;
        we_cnt_d  = we_cnt_q;
        gap_cnt_d = gap_cnt_q;

        if (abort) begin
            // addr/dout deliberately hold; only the strobe is dropped.
            if (state_q != ST_IDLE) begin
                state_d = ST_IDLE;
                we_d    = 1'b0;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        state_d  = ST_ADDR_WR;
                        addr_d   = OPL2_PORT_INDEX;
                        dout_d   = cmd_reg;
                        we_d     = 1'b1;
                        we_cnt_d = WE_LOAD;
                        data_d   = cmd_data;
                        ticks_d  = cmd_delay;
                    end
                end
                ST_ADDR_WR: begin
                    if (we_cnt_q == '0) begin
                        state_d   = ST_ADDR_GAP;
                        we_d      = 1'b0;
                        gap_cnt_d = AGAP_LOAD;
                    end else begin
                        we_cnt_d = we_cnt_q - 1'b1;
                    end
                end
                ST_ADDR_GAP: begin
                    if (gap_cnt_q == '0) begin
                        state_d  = ST_DATA_WR;
                        addr_d   = OPL2_PORT_DATA;
                        dout_d   = data_q;
                        we_d     = 1'b1;
                        we_cnt_d = WE_LOAD;
                    end else begin
                        gap_cnt_d = gap_cnt_q - 1'b1;
                    end
                end
                ST_DATA_WR: begin
                    if (we_cnt_q == '0) begin
                        state_d   = ST_DATA_GAP;
                        we_d      = 1'b0;
                        gap_cnt_d = DGAP_LOAD;
                    end else begin
                        we_cnt_d = we_cnt_q - 1'b1;
                    end
                end
                ST_DATA_GAP: begin
                    if (gap_cnt_q == '0) begin
                        state_d = (ticks_q != 16'd0) ? ST_DELAY : ST_IDLE;
                    end else begin
                        gap_cnt_d = gap_cnt_q - 1'b1;
                    end
                end
                ST_DELAY: begin
                    // Counting down from the loaded value means 16'hFFFF cannot wrap.
                    if (tick_w) begin
                        ticks_d = ticks_q - 16'd1;
                        if (ticks_q == 16'd1) begin
                            state_d = ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    we_d    = 1'b0;
                end
            endcase
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            addr_q    <= 1'b0;
            dout_q    <= 8'd0;
            we_q      <= 1'b0;
            busy_q    <= 1'b0;
            data_q    <= 8'd0;
            ticks_q   <= 16'd0;
            we_cnt_q  <= '0;
            gap_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            dout_q    <= dout_d;
            we_q      <= we_d;
            busy_q    <= busy_d;
            data_q    <= data_d;
            ticks_q   <= ticks_d;
            we_cnt_q  <= we_cnt_d;
            gap_cnt_q <= gap_cnt_d;
        end
    end

    assign addr = addr_q;
    assign dout = dout_q;
    assign we   = we_q;
    assign busy = busy_q;

endmodule
`default_nettype wire
